// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execution stage: opcodes, FSM states,
// flag bit positions and a flag-packing helper.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_INC   = 4'd6,
    OP_DEC   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_MUL   = 4'd10,
    OP_PASSB = 4'd11,
    OP_PASSA = 4'd12   // 13..15 also decode as PASS A
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Place the four flag bits at their architectural positions.
  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_Z] = z;
    f[FLG_N] = n;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Bus between the register group / microsequencer (master) and the
// ALU execution stage (slave).
interface alu_exec_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] d_in;
  logic             ld_a;
  logic             ld_b;
  logic [3:0]       op;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] prod_hi;
  logic [3:0]       flags;

  modport master (
    output s_in, d_in, ld_a, ld_b, op, start,
    input  busy, done, result, prod_hi, flags
  );

  modport slave (
    input  s_in, d_in, ld_a, ld_b, op, start,
    output busy, done, result, prod_hi, flags
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per clock, WIDTH iterations.
// done_o / prod_o are combinational during the final iteration so the
// parent can capture the product on the same edge the sequence ends.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o = busy_q && (cnt_q == CNT_LAST);
  assign prod_o = acc_d;
  assign busy_o = busy_q;

  // Capture operands on start, then add/shift once per cycle until the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i && !busy_q) begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      mcand_q  <= {{WIDTH{1'b0}}, mcand_i};
      mplier_q <= mplier_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execution stage: operand latches A/B, combinational 8-bit ALU,
// registered result/prod_hi/flags and a two-state IDLE/MUL controller.
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  state_e             state_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   prod_hi_q;
  logic [3:0]         flags_q;
  logic               done_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH:0]     inc_w;
  logic [WIDTH:0]     dec_w;

  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  // Operations read A/B as they were before the edge, so a load coinciding
  // with start does not affect the operation started at that edge.
  assign mul_start = (state_q == ST_IDLE) && bus.start && (bus.op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .mcand_i  (a_q),
    .mplier_i (b_q),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .prod_o   (mul_prod)
  );

  // Operand latches are honoured every cycle, even while MUL iterates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (bus.ld_a) a_q <= bus.s_in;
      if (bus.ld_b) b_q <= bus.d_in;
    end
  end

  // WIDTH+1-bit intermediates expose carry/borrow in the top bit.
  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};
  assign inc_w = {1'b0, a_q} + 1'b1;
  assign dec_w = {1'b0, a_q} - 1'b1;

  // Single-cycle ALU: result plus carry and signed-overflow for the current opcode.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    alu_res = a_q;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = add_w[MSB:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (add_w[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_w[MSB:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (a_q[MSB] != b_q[MSB]) && (sub_w[MSB] != a_q[MSB]);
      end
      OP_AND:   alu_res = a_q & b_q;
      OP_OR:    alu_res = a_q | b_q;
      OP_XOR:   alu_res = a_q ^ b_q;
      OP_NOT:   alu_res = ~a_q;
      OP_INC: begin
        alu_res = inc_w[MSB:0];
        alu_c   = inc_w[WIDTH];
        alu_v   = !a_q[MSB] && inc_w[MSB];
      end
      OP_DEC: begin
        alu_res = dec_w[MSB:0];
        alu_c   = dec_w[WIDTH];
        alu_v   = a_q[MSB] && !dec_w[MSB];
      end
      OP_SHL: begin
        alu_res = {a_q[MSB-1:0], 1'b0};
        alu_c   = a_q[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_q[MSB:1]};
        alu_c   = a_q[0];
      end
      OP_PASSB: alu_res = b_q;
      default:  alu_res = a_q;   // PASS A (12..15); MUL result comes from the sequencer
    endcase
  end

  // Controller: single-cycle ops retire at the start edge, MUL retires when
  // the sequencer reports its final iteration; done pulses one cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      prod_hi_q <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MUL) begin
              state_q <= ST_MUL;
            end else begin
              result_q <= alu_res;
              flags_q  <= pack_flags(alu_res == '0, alu_res[MSB], alu_c, alu_v);
              done_q   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result_q  <= mul_prod[MSB:0];
            prod_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
            flags_q   <= pack_flags(mul_prod[MSB:0] == '0, mul_prod[MSB],
                                    mul_prod[2*WIDTH-1:WIDTH] != '0, 1'b0);
            done_q    <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy    = mul_busy;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.prod_hi = prod_hi_q;
  assign bus.flags   = flags_q;

endmodule
